imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader.sv | 113 +++++++++++
 tb/tb_imem_boot_loader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: takes a byte stream (count header, little-endian payload words, XOR checksum),
// writes each word into instruction memory, then releases the core and hands it the address bus.
module imem_boot_loader #(
   parameter int DEPTH = 256,
   parameter int BASE  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   input  logic [31:0] cpu_addr,
   output logic [31:0] imem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   output logic        cpu_rst,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {HDR0, HDR1, DATA, WR, CSUM, RUN, ERR} state_t;

   localparam logic [16:0] DEPTH_W = 17'(DEPTH);
   localparam logic [31:0] BASE_W  = 32'(BASE);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] idx_q, idx_d;
   logic [1:0]  lane_q, lane_d;
   logic [7:0]  csum_q, csum_d;
   logic [31:0] word_q, word_d;
   logic        ready_q, we_q, done_q, err_q, cpu_rst_q;
   logic        acc;
   logic [15:0] full_cnt;

   assign acc      = byte_valid & ready_q;
   assign full_cnt = {byte_data, cnt_q[7:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      lane_d  = lane_q;
      csum_d  = csum_q;
      word_d  = word_q;
      unique case (state_q)
         HDR0: if (acc) begin
            cnt_d[7:0] = byte_data;
            state_d    = HDR1;
         end
         HDR1: if (acc) begin
            cnt_d[15:8] = byte_data;
            if ({1'b0, full_cnt} > DEPTH_W) state_d = ERR;
            else if (full_cnt == 16'd0)     state_d = CSUM;
            else                            state_d = DATA;
         end
         DATA: if (acc) begin
            word_d[{lane_q, 3'b000} +: 8] = byte_data;
            csum_d = csum_q ^ byte_data;
            lane_d = lane_q + 2'd1;
            if (lane_q == 2'd3) state_d = WR;
         end
         WR: begin
            idx_d   = idx_q + 16'd1;
            state_d = (idx_q + 16'd1 == cnt_q) ? CSUM : DATA;
         end
         CSUM: if (acc) state_d = (byte_data == csum_q) ? RUN : ERR;
         RUN:  state_d = RUN;
         ERR:  state_d = ERR;
         default: state_d = ERR;
      endcase
   end

   // Handshake and status outputs are registered from the next state so they
   // line up with the state they describe and are clean straight out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= HDR0;
         cnt_q     <= '0;
         idx_q     <= '0;
         lane_q    <= '0;
         csum_q    <= '0;
         word_q    <= '0;
         ready_q   <= 1'b0;
         we_q      <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         cpu_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         lane_q    <= lane_d;
         csum_q    <= csum_d;
         word_q    <= word_d;
         ready_q   <= (state_d == HDR0) || (state_d == HDR1) ||
                      (state_d == DATA) || (state_d == CSUM);
         we_q      <= (state_d == WR);
         done_q    <= (state_d == RUN);
         err_q     <= (state_d == ERR);
         cpu_rst_q <= (state_d != RUN);
      end
   end

   assign byte_ready = ready_q;
   assign mem_we     = we_q;
   assign mem_wdata  = word_q;
   assign done       = done_q;
   assign err        = err_q;
   assign cpu_rst    = cpu_rst_q;
   assign imem_addr  = (state_q == RUN) ? cpu_addr : BASE_W + {16'd0, idx_q};

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: normal load, bad checksum, empty and oversize
// images, stalled byte stream, mid-load reset, and RUN-time address pass-through.
module tb_imem_boot_loader;
   logic        clk = 1'b0;
   logic        rst;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic [31:0] cpu_addr;
   logic [31:0] imem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic        cpu_rst;
   logic        done;
   logic        err;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] wa_q [$];
   logic [31:0] wd_q [$];

   imem_boot_loader #(.DEPTH(256), .BASE(0)) dut (
      .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .cpu_addr(cpu_addr), .imem_addr(imem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rst && mem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(mem_wdata);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; cpu_addr = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, byte_ready}, 0);
      chk("rst_cpurst", {31'd0, cpu_rst}, 1);
      chk("rst_we", {31'd0, mem_we}, 0);
      chk("rst_done", {31'd0, done}, 0);
      rst = 1'b1;
      wa_q.delete(); wd_q.delete();
      @(negedge clk);
   endtask

   // called at a negedge; returns at a negedge after the byte was taken
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      byte_valid = 1'b1; byte_data = b;
      while (!byte_ready && t < 50) begin @(negedge clk); t++; end
      if (!byte_ready) chk("ready_timeout", {31'd0, byte_ready}, 1);
      else @(posedge clk);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_stream(input logic [7:0] s [$], input int gapmax);
      foreach (s[i]) begin
         if (gapmax > 0) repeat ($urandom_range(1, gapmax)) @(negedge clk);
         send_byte(s[i]);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_good_load(input string tag);
      chk({tag, "_nwr"}, wa_q.size(), 2);
      if (wa_q.size() >= 2) begin
         chk({tag, "_a0"}, wa_q[0], 32'd0);
         chk({tag, "_d0"}, wd_q[0], 32'h00500093);
         chk({tag, "_a1"}, wa_q[1], 32'd1);
         chk({tag, "_d1"}, wd_q[1], 32'h00100113);
      end
      chk({tag, "_done"}, {31'd0, done}, 1);
      chk({tag, "_cpurst"}, {31'd0, cpu_rst}, 0);
      chk({tag, "_err"}, {31'd0, err}, 0);
      chk({tag, "_ready"}, {31'd0, byte_ready}, 0);
   endtask

   logic [7:0] good [$];
   logic [7:0] bad  [$];
   logic [7:0] empty[$];
   logic [7:0] big  [$];
   logic [31:0] pc_v [4];

   initial begin
      good  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
      bad   = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hC0};
      empty = '{8'h00, 8'h00, 8'h00};
      big   = '{8'h01, 8'h01};
      pc_v  = '{32'h0, 32'h1, 32'h5, 32'hFF};
      rst = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; cpu_addr = '0;

      // 1: good image, byte every cycle
      do_reset();
      chk("ready_after_release", {31'd0, byte_ready}, 1);
      send_stream(good, 0);
      check_good_load("s1");

      // 6: address pass-through in RUN
      foreach (pc_v[i]) begin
         @(negedge clk);
         cpu_addr = pc_v[i];
         #1;
         chk("pc_pass", imem_addr, pc_v[i]);
         chk("pc_we", {31'd0, mem_we}, 0);
      end

      // 2: bad checksum, then extra bytes ignored
      do_reset();
      send_stream(bad, 0);
      chk("s2_nwr", wa_q.size(), 2);
      chk("s2_err", {31'd0, err}, 1);
      chk("s2_cpurst", {31'd0, cpu_rst}, 1);
      chk("s2_done", {31'd0, done}, 0);
      chk("s2_ready", {31'd0, byte_ready}, 0);
      byte_valid = 1'b1; byte_data = 8'h55;
      repeat (5) @(negedge clk);
      byte_valid = 1'b0;
      chk("s2_nwr_after", wa_q.size(), 2);
      chk("s2_err_after", {31'd0, err}, 1);

      // 3a: empty image
      do_reset();
      send_stream(empty, 0);
      chk("s3_nwr", wa_q.size(), 0);
      chk("s3_done", {31'd0, done}, 1);
      chk("s3_cpurst", {31'd0, cpu_rst}, 0);

      // 3b: N = 257 exceeds DEPTH
      do_reset();
      send_byte(big[0]);
      send_byte(big[1]);
      chk("s3b_err", {31'd0, err}, 1);
      chk("s3b_ready", {31'd0, byte_ready}, 0);
      repeat (3) @(negedge clk);
      chk("s3b_nwr", wa_q.size(), 0);

      // 4: random idle gaps between bytes
      do_reset();
      send_stream(good, 3);
      check_good_load("s4");

      // 5: reset after 6 bytes, then resend
      do_reset();
      for (int i = 0; i < 6; i++) send_byte(good[i]);
      #1 rst = 1'b0;
      #1;
      chk("s5_ready", {31'd0, byte_ready}, 0);
      chk("s5_cpurst", {31'd0, cpu_rst}, 1);
      chk("s5_we", {31'd0, mem_we}, 0);
      @(negedge clk);
      rst = 1'b1;
      wa_q.delete(); wd_q.delete();
      #1 chk("s5_ready_rel", {31'd0, byte_ready}, 0);
      @(negedge clk);
      chk("s5_ready_up", {31'd0, byte_ready}, 1);
      send_stream(good, 0);
      check_good_load("s5");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
